// File: rtl/div_nr_seq.sv
// Sequential non-restoring divider, one quotient bit per clock, with FRAC fractional bits.
// Define DIV_SIGNED_EN for two's-complement operands (truncating quotient, remainder follows dividend sign).
module div_nr_seq #(
    parameter int N    = 16,
    parameter int FRAC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N-1:0]      dividend,
    input  logic [N-1:0]      divisor,
    output logic              busy,
    output logic              done,
    output logic [N+FRAC-1:0] quotient,
    output logic [N-1:0]      remainder,
    output logic              div_zero
);

    // state | meaning
    // IDLE  | waiting for start; zero-divisor requests are answered here directly
    // CALC  | one non-restoring step per edge, N+FRAC steps
    // FIX   | remainder correction, sign fix-up, result registered, done pulsed
    localparam int QW = N + FRAC;
    localparam int CW = $clog2(QW + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]    state;
    logic [N:0]    p;
    logic [N-1:0]  d;
    logic [N-1:0]  a;
    logic [QW-1:0] q;
    logic [CW-1:0] cnt;

    logic [N:0]    p_sh;
    logic [N:0]    p_nx;
    logic [N-1:0]  r_fix;
    logic [N-1:0]  dvd_in;
    logic [N-1:0]  dvs_in;
    logic [QW-1:0] q_out;
    logic [N-1:0]  r_out;

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    always_comb begin
        dvd_in = dividend[N-1] ? (~dividend + 1'b1) : dividend;
        dvs_in = divisor[N-1]  ? (~divisor + 1'b1)  : divisor;
        q_out  = neg_q ? (~q + 1'b1) : q;
        r_out  = neg_r ? (~r_fix + 1'b1) : r_fix;
    end
`else
    always_comb begin
        dvd_in = dividend;
        dvs_in = divisor;
        q_out  = q;
        r_out  = r_fix;
    end
`endif

    // Dividend bits enter MSB-first; zeros shifted into a supply the fractional steps.
    always_comb begin
        p_sh  = {p[N-1:0], a[N-1]};
        p_nx  = p[N] ? (p_sh + {1'b0, d}) : (p_sh - {1'b0, d});
        r_fix = p[N] ? (p[N-1:0] + d) : p[N-1:0];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            p         <= '0;
            d         <= '0;
            a         <= '0;
            q         <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            a     <= dvd_in;
                            d     <= dvs_in;
                            p     <= '0;
                            q     <= '0;
                            cnt   <= '0;
                            state <= CALC;
`ifdef DIV_SIGNED_EN
                            neg_q <= dividend[N-1] ^ divisor[N-1];
                            neg_r <= dividend[N-1];
`endif
                        end
                    end
                end
                CALC: begin
                    p   <= p_nx;
                    a   <= {a[N-2:0], 1'b0};
                    q   <= {q[QW-2:0], ~p_nx[N]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(QW - 1))
                        state <= FIX;
                end
                FIX: begin
                    quotient  <= q_out;
                    remainder <= r_out;
                    div_zero  <= 1'b0;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_nr_seq.sv
// Scoreboard bench for div_nr_seq: directed operations, expected results queued at start, checked at done.
module tb_div_nr_seq;

    localparam int N = 16;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, div_zero;
    logic [15:0] quotient, remainder;

    logic        start8 = 1'b0;
    logic [15:0] dividend8 = '0;
    logic [15:0] divisor8 = '0;
    logic        busy8, done8, div_zero8;
    logic [23:0] quotient8;
    logic [15:0] remainder8;

    int vectors = 0;
    int errs = 0;
    int cyc = 0;
    exp_t sb[$];

    div_nr_seq #(.N(N), .FRAC(0)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    div_nr_seq #(.N(N), .FRAC(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(dividend8), .divisor(divisor8),
        .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8), .div_zero(div_zero8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", {16'd0, quotient}, {16'd0, e.q});
                chk("remainder", {16'd0, remainder}, {16'd0, e.r});
                chk("div_zero", {31'd0, div_zero}, {31'd0, e.z});
            end
        end
    end

    // Caller is at a negedge; the following posedge is the accepting edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] eq, input logic [15:0] er, input logic ez);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.q = eq; e.r = er; e.z = ez;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int pulse_at, output int lat, output int nbusy);
        int e_cyc;
        e_cyc = 0;
        lat   = -1;
        nbusy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start  = 1'b0;
                e_cyc  = cyc;
            end
            if (i == pulse_at) begin
                dividend = 16'd50;
                divisor  = 16'd5;
                start    = 1'b1;
            end
            if (i == pulse_at + 1)
                start = 1'b0;
            if (done) begin
                lat = cyc - e_cyc;
                break;
            end
            if (busy)
                nbusy++;
        end
        if (lat < 0)
            chk("done_timeout", 32'd0, 32'd1);
    endtask

    int lat, nb, cnt_done;

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quot", {16'd0, quotient}, 32'd0);
        chk("rst_rem", {16'd0, remainder}, 32'd0);
        chk("rst_dz", {31'd0, div_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        start_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        wait_done(-1, lat, nb);
        chk("lat_100_7", lat, 32'd17);
        chk("busy_cycles_100_7", nb, 32'd17);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("done_width", {31'd0, done}, 32'd0);

        // FRAC=8 instance: 1/3 -> 0x55 rem 1
        dividend8 = 16'd1; divisor8 = 16'd3; start8 = 1'b1;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) start8 = 1'b0;
            if (done8) begin lat = i; break; end
        end
        chk("lat_frac8", lat, 32'd25);
        chk("quot_frac8", {8'd0, quotient8}, 32'h55);
        chk("rem_frac8", {16'd0, remainder8}, 32'd1);
        chk("dz_frac8", {31'd0, div_zero8}, 32'd0);

        start_op(16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1);
        wait_done(-1, lat, nb);
        chk("lat_div0", lat, 32'd0);
        chk("busy_div0", nb + {31'd0, busy}, 32'd0);
        @(negedge clk);
        start_op(16'd9, 16'd3, 16'd3, 16'd0, 1'b0);
        wait_done(-1, lat, nb);
        chk("lat_9_3", lat, 32'd17);

        @(negedge clk);
        start_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
        wait_done(4, lat, nb);
        chk("lat_ignored_start", lat, 32'd17);
        start_op(16'd5, 16'd10, 16'd0, 16'd5, 1'b0);
        wait_done(-1, lat, nb);
        chk("lat_back_to_back", lat, 32'd17);

        @(negedge clk);
        dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_quot", {16'd0, quotient}, 32'd0);
        chk("abort_rem", {16'd0, remainder}, 32'd0);
        chk("abort_dz", {31'd0, div_zero}, 32'd0);
        rst = 1'b0;
        cnt_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) cnt_done++;
        end
        chk("abort_no_done", cnt_done, 32'd0);
        start_op(16'd200, 16'd13, 16'd15, 16'd5, 1'b0);
        wait_done(-1, lat, nb);
        chk("lat_200_13", lat, 32'd17);

`ifdef DIV_SIGNED_EN
        @(negedge clk);
        start_op(16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0);
        wait_done(-1, lat, nb);
        chk("lat_signed", lat, 32'd17);
        @(negedge clk);
        start_op(16'd100, 16'hFFF9, 16'hFFF2, 16'd2, 1'b0);
        wait_done(-1, lat, nb);
        @(negedge clk);
        start_op(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0);
        wait_done(-1, lat, nb);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
